// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one single-port memory slave between instruction fetch (I)
// and load/store (D). D has priority; a saturating D streak counter forces an I grant.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ren,
  input  logic [31:0] i_addr,
  output logic [31:0] i_load,
  output logic [1:0]  i_state,
  input  logic        d_ren,
  input  logic [3:0]  d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_store,
  output logic [31:0] d_load,
  output logic [1:0]  d_state,
  output logic        m_ren,
  output logic [3:0]  m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_store,
  input  logic [31:0] m_load,
  input  logic [1:0]  m_state
);
  localparam logic [1:0] RAM_IDLE = 2'd0;
  localparam logic [1:0] RAM_WAIT = 2'd1;
  localparam logic [1:0] RAM_DONE = 2'd2;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_I = 2'd1, ARB_D = 2'd2} arb_state_t;

  arb_state_t r_state;
  logic [3:0] r_streak;
  logic       w_i_req, w_d_req, w_d_win, w_release;

  assign w_i_req = i_ren;
  assign w_d_req = d_ren | (|d_wen);
  // D only wins against a waiting I while its streak is below the limit
  assign w_d_win = w_d_req & (~w_i_req | (r_streak < STREAK_MAX));

  // A grant ends on DONE, or when the owner dropped its request and the slave went idle
  always_comb begin
    w_release = 1'b0;
    if (m_state == RAM_DONE)
      w_release = 1'b1;
    else if (m_state == RAM_IDLE)
      w_release = (r_state == ARB_I) ? ~w_i_req : ~w_d_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ARB_IDLE;
      r_streak <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_d_win) begin
            r_state  <= ARB_D;
            r_streak <= w_i_req ? r_streak + 4'd1 : 4'd0;
          end else if (w_i_req) begin
            r_state  <= ARB_I;
            r_streak <= '0;
          end
        end
        ARB_I, ARB_D: if (w_release) r_state <= ARB_IDLE;
        default:      r_state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    m_ren   = 1'b0;
    m_wen   = '0;
    m_addr  = '0;
    m_store = '0;
    i_load  = '0;
    d_load  = '0;
    i_state = w_i_req ? RAM_WAIT : RAM_IDLE;
    d_state = w_d_req ? RAM_WAIT : RAM_IDLE;
    if (rst) begin
      i_state = RAM_IDLE;
      d_state = RAM_IDLE;
    end else begin
      case (r_state)
        ARB_I: begin
          m_ren   = i_ren;
          m_addr  = i_addr;
          i_state = m_state;
          i_load  = m_load;
        end
        ARB_D: begin
          m_ren   = d_ren;
          m_wen   = d_wen;
          m_addr  = d_addr;
          m_store = d_store;
          d_state = m_state;
          d_load  = m_load;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (!rst) assert (!(i_state == RAM_DONE && d_state == RAM_DONE));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: TB slave memory with variable latency, a grant/streak
// reference model and memory scoreboard checked every cycle, plus directed literal cases.
module tb_mem_arbiter;
  localparam int MAXS = 4;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;

  logic        clk = 1'b0, rst = 1'b1;
  logic        i_ren = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_load;
  logic [1:0]  i_state;
  logic        d_ren = 1'b0;
  logic [3:0]  d_wen = '0;
  logic [31:0] d_addr = '0, d_store = '0;
  logic [31:0] d_load;
  logic [1:0]  d_state;
  logic        m_ren;
  logic [3:0]  m_wen;
  logic [31:0] m_addr, m_store, m_load;
  logic [1:0]  m_state;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .i_ren(i_ren), .i_addr(i_addr), .i_load(i_load), .i_state(i_state),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store),
    .d_load(d_load), .d_state(d_state),
    .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_store(m_store),
    .m_load(m_load), .m_state(m_state)
  );

  function automatic logic [31:0] init_word(input int k);
    return (k == 0) ? 32'h0000_0513 : 32'h1000_0000 + 32'(k) * 32'h0101_0101;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave: state follows the request combinationally, DONE after lat+2 request cycles
  logic [31:0] smem [16];
  int lat = 0, s_cnt = 0;
  wire s_req = m_ren | (|m_wen);
  always_comb begin
    m_state = IDLE;
    if (s_req) m_state = (s_cnt >= lat + 2) ? DONE : WAIT;
  end
  assign m_load = (m_state == DONE) ? smem[m_addr[5:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst) begin
      s_cnt <= 0;
      for (int k = 0; k < 16; k++) smem[k] <= init_word(k);
    end else if (s_req && m_state != DONE) begin
      s_cnt <= s_cnt + 1;
    end else begin
      s_cnt <= 0;
      if (m_state == DONE)
        for (int b = 0; b < 4; b++)
          if (m_wen[b]) smem[m_addr[5:2]][8*b +: 8] <= m_store[8*b +: 8];
    end
  end

  // Reference model: who owns the slave, D streak, and expected memory contents
  typedef enum int {O_NONE, O_I, O_D} own_t;
  own_t        own = O_NONE;
  int          streak = 0;
  logic [31:0] rmem [16];
  int          gq[$];

  always @(negedge clk) begin
    logic ireq, dreq, greq;
    logic [1:0] ei, ed;
    logic [31:0] eil, edl;
    ireq = i_ren;
    dreq = d_ren | (|d_wen);
    if (rst) begin
      chk("rst_m_ren", m_ren, 0);     chk("rst_m_wen", m_wen, 0);
      chk("rst_m_addr", m_addr, 0);   chk("rst_m_store", m_store, 0);
      chk("rst_i_state", i_state, IDLE); chk("rst_d_state", d_state, IDLE);
      chk("rst_i_load", i_load, 0);   chk("rst_d_load", d_load, 0);
      own = O_NONE;
      streak = 0;
      for (int k = 0; k < 16; k++) rmem[k] = init_word(k);
    end else begin
      ei = ireq ? WAIT : IDLE;
      ed = dreq ? WAIT : IDLE;
      eil = '0;
      edl = '0;
      if (own == O_NONE) begin
        chk("idle_m_ren", m_ren, 0);
        chk("idle_m_wen", m_wen, 0);
      end else if (own == O_I) begin
        chk("i_m_ren", m_ren, i_ren);   chk("i_m_wen", m_wen, 0);
        chk("i_m_addr", m_addr, i_addr); chk("i_m_store", m_store, 0);
        ei = m_state;
        eil = m_load;
      end else begin
        chk("d_m_ren", m_ren, d_ren);   chk("d_m_wen", m_wen, d_wen);
        chk("d_m_addr", m_addr, d_addr); chk("d_m_store", m_store, d_store);
        ed = m_state;
        edl = m_load;
      end
      chk("i_state", i_state, ei); chk("d_state", d_state, ed);
      chk("i_load", i_load, eil);  chk("d_load", d_load, edl);
      chk("one_done", (i_state == DONE && d_state == DONE), 0);
      if (own == O_I && m_state == DONE && ireq)
        chk("i_rdata", i_load, rmem[i_addr[5:2]]);
      if (own == O_D && m_state == DONE) begin
        if (d_wen != 0) begin
          for (int b = 0; b < 4; b++)
            if (d_wen[b]) rmem[d_addr[5:2]][8*b +: 8] = d_store[8*b +: 8];
        end else begin
          chk("d_rdata", d_load, rmem[d_addr[5:2]]);
        end
      end
      if (own == O_NONE) begin
        if (dreq && (!ireq || streak < MAXS)) begin
          own = O_D;
          streak = ireq ? ((streak + 1 > MAXS) ? MAXS : streak + 1) : 0;
          gq.push_back(2);
        end else if (ireq) begin
          own = O_I;
          streak = 0;
          gq.push_back(1);
        end
      end else begin
        greq = (own == O_I) ? ireq : dreq;
        if (m_state == DONE || (!greq && m_state == IDLE)) own = O_NONE;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1);
  end

  logic [1:0] exp_s [4] = '{WAIT, WAIT, WAIT, DONE};
  int exp_g [6] = '{2, 2, 2, 2, 1, 2};

  initial begin
    int td, ti, hold, stable, dn, stop, n;
    logic [31:0] a0;
    logic ni, nd;
    logic [3:0] nw;
    logic [31:0] nia, nda, nds;

    // Reset with both requests asserted
    i_ren = 1'b1; d_ren = 1'b1;
    @(negedge clk); #1;
    chk("lit_rst_m_ren", m_ren, 0);
    chk("lit_rst_i_state", i_state, IDLE);
    chk("lit_rst_d_state", d_state, IDLE);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; i_ren = 1'b0; d_ren = 1'b0;

    // I-only read at 0x0, cycles 0..3
    i_ren = 1'b1; i_addr = 32'h0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk); #1;
      chk($sformatf("lit_iread_state_c%0d", c), i_state, exp_s[c]);
      chk($sformatf("lit_iread_d_state_c%0d", c), d_state, IDLE);
      chk($sformatf("lit_iread_m_wen_c%0d", c), m_wen, 0);
    end
    chk("lit_iread_data", i_load, 32'h0000_0513);
    @(posedge clk); #1;
    i_ren = 1'b0;

    // Simultaneous I read @0x10 and D half-word write @0x20
    i_ren = 1'b1; i_addr = 32'h10;
    d_wen = 4'b0011; d_addr = 32'h20; d_store = 32'h0000_A5A5;
    td = -1; ti = -1;
    for (int t = 0; t < 60 && ti < 0; t++) begin
      @(negedge clk); #1;
      if (d_state == DONE && td < 0) begin
        td = t;
        chk("lit_sim_i_waits", i_state, WAIT);
      end
      if (i_state == DONE) ti = t;
      @(posedge clk); #1;
      if (td == t) d_wen = 4'b0000;
      if (ti == t) i_ren = 1'b0;
    end
    chk("lit_sim_d_first", (td >= 0 && ti > td), 1);
    chk("lit_sim_gap", 32'(ti - td), 32'd4);
    i_ren = 1'b0; d_wen = 4'b0000;

    // Read back the written half-word
    d_ren = 1'b1; d_addr = 32'h20;
    dn = 0;
    for (int t = 0; t < 60 && !dn; t++) begin
      @(negedge clk); #1;
      if (d_state == DONE) begin
        dn = 1;
        chk("lit_readback", {16'h0, d_load[15:0]}, 32'h0000_A5A5);
      end
      @(posedge clk); #1;
    end
    chk("lit_readback_done", dn, 1);
    d_ren = 1'b0;

    // D streak against a waiting I
    @(negedge clk); #1;
    gq.delete();
    @(posedge clk); #1;
    i_ren = 1'b1; i_addr = 32'h4; d_ren = 1'b1; d_addr = 32'h8;
    stop = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); #1;
      if (gq.size() >= 6) stop = 1;
      ni = i_ren; nd = d_ren;
      if (stop && i_state == DONE) ni = 1'b0;
      if (stop && d_state == DONE) nd = 1'b0;
      @(posedge clk); #1;
      i_ren = ni; d_ren = nd;
      if (!i_ren && !d_ren) break;
    end
    chk("lit_streak_quiet", {i_ren, d_ren}, 0);
    chk("lit_streak_count", (gq.size() >= 6), 1);
    for (int k = 0; k < 6 && k < gq.size(); k++)
      chk($sformatf("lit_streak_order%0d", k), gq[k], exp_g[k]);
    i_ren = 1'b0; d_ren = 1'b0;

    // Slave latency 2: grant held with a stable address
    lat = 2;
    i_ren = 1'b1; i_addr = 32'h4;
    hold = 0; stable = 1; dn = 0; a0 = '0;
    for (int t = 0; t < 40 && !dn; t++) begin
      @(negedge clk); #1;
      if (m_ren) begin
        if (hold == 0) a0 = m_addr;
        else if (m_addr !== a0) stable = 0;
        hold++;
      end
      if (i_state == DONE) dn = 1;
      @(posedge clk); #1;
      if (dn) i_ren = 1'b0;
    end
    chk("lit_lat2_done", dn, 1);
    chk("lit_lat2_hold", hold, 5);
    chk("lit_lat2_addr_stable", stable, 1);

    // Reset during a D write wait
    d_wen = 4'hF; d_addr = 32'h30; d_store = 32'hCAFE_F00D;
    @(negedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("lit_mid_wait_state", d_state, WAIT);
    chk("lit_mid_wait_m_wen", m_wen, 4'hF);
    @(posedge clk); #1;
    rst = 1'b1; d_wen = 4'h0;
    @(negedge clk); #1;
    chk("lit_rst_mid_d_state", d_state, IDLE);
    chk("lit_rst_mid_m_wen", m_wen, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("lit_post_rst_d_state", d_state, IDLE);
    chk("lit_post_rst_m_wen", m_wen, 0);
    chk("lit_post_rst_m_ren", m_ren, 0);
    @(posedge clk); #1;
    lat = 0;

    // Random traffic
    for (n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      ni = i_ren; nia = i_addr;
      if (i_ren && i_state == DONE) ni = 1'b0;
      if (!ni && $urandom_range(0, 3) == 0) begin
        ni = 1'b1;
        nia = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      nd = d_ren; nw = d_wen; nda = d_addr; nds = d_store;
      if ((d_ren || d_wen != 0) && d_state == DONE) begin nd = 1'b0; nw = 4'h0; end
      if (!nd && nw == 0 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) nd = 1'b1;
        else nw = 4'($urandom_range(1, 15));
        nda = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        nds = $urandom;
      end
      @(posedge clk); #1;
      if (!i_ren && !d_ren && d_wen == 0 && m_state == IDLE) lat = $urandom_range(0, 2);
      i_ren = ni; i_addr = nia;
      d_ren = nd; d_wen = nw; d_addr = nda; d_store = nds;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
